// File: rtl/alarm_ring_ctrl_pkg.sv
// rtl/alarm_ring_ctrl_pkg.sv - shared types, field codes, limits and wrap helper for the alarm block
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EDIT    = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } state_t;

  // Field under edit, as presented on alarm_mode
  localparam logic [2:0] FLD_NONE = 3'd0;
  localparam logic [2:0] FLD_SEC  = 3'd1;
  localparam logic [2:0] FLD_MIN  = 3'd2;
  localparam logic [2:0] FLD_HOUR = 3'd3;

  localparam logic [5:0] SEC_MAX  = 6'd59;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [5:0] HOUR_MAX = 6'd23;

  // Step a time field by one in either direction, wrapping within 0..lim
  function automatic logic [5:0] fld_step(input logic [5:0] val,
                                          input logic [5:0] lim,
                                          input logic       inc);
    if (inc) begin
      return (val >= lim) ? 6'd0 : val + 6'd1;
    end
    return (val == 6'd0) ? lim : val - 6'd1;
  endfunction

endpackage

// File: rtl/alarm_ring_ctrl_btn_edge.sv
// rtl/alarm_ring_ctrl_btn_edge.sv - rising-edge press detector for a vector of button levels
module btn_edge #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] level,
  output logic [W-1:0] press
);

  logic [W-1:0] prev;

  // Previous level; resets high so a button held through reset is not a press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= '1;
    end else begin
      prev <= level;
    end
  end

  assign press = level & ~prev;

endmodule

// File: rtl/alarm_ring_ctrl.sv
// rtl/alarm_ring_ctrl.sv - alarm time editor, arm control and ring/snooze sequencer
module alarm_ring_ctrl
  import alarm_pkg::*;
#(
  parameter logic [3:0] ALARM_MODE  = 4'd3,
  parameter int         RING_SECS   = 60,
  parameter int         SNOOZE_SECS = 300
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic       middle,
  input  logic [3:0] mode,
  input  logic [5:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  output logic [2:0] alarm_mode,
  output logic [5:0] al_hour,
  output logic [5:0] al_min,
  output logic [5:0] al_sec,
  output logic       armed,
  output logic       ring
);

  localparam logic [8:0] RING_CNT   = 9'(RING_SECS - 1);
  localparam logic [8:0] SNOOZE_CNT = 9'(SNOOZE_SECS - 1);

  state_t     state;
  logic [8:0] cnt;
  logic [4:0] prs;

  // Bit order: middle, up, down, left, right
  btn_edge #(.W(5)) u_btn_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .level ({middle, up, down, left, right}),
    .press (prs)
  );

  // One press acts per cycle, chosen by priority middle > up > down > left > right
  logic p_mid, p_up, p_dn, p_lf, p_rt, any_press;
  assign p_mid     = prs[4];
  assign p_up      = prs[3] & ~prs[4];
  assign p_dn      = prs[2] & ~|prs[4:3];
  assign p_lf      = prs[1] & ~|prs[4:2];
  assign p_rt      = prs[0] & ~|prs[4:1];
  assign any_press = |prs;

  logic sel_mode, match;
  assign sel_mode = (mode == ALARM_MODE);
  assign match    = armed && tick_1hz &&
                    (cur_hour == al_hour) && (cur_min == al_min) && (cur_sec == al_sec);

  // Main sequencer; any press in a cycle discards that cycle's tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      alarm_mode <= FLD_NONE;
      al_hour    <= 6'd0;
      al_min     <= 6'd0;
      al_sec     <= 6'd0;
      armed      <= 1'b0;
      ring       <= 1'b0;
      cnt        <= 9'd0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_mode && p_mid) begin
            state      <= EDIT;
            alarm_mode <= FLD_SEC;
          end else if (sel_mode && (p_up || p_dn)) begin
            armed <= ~armed;
          end else if (!any_press && match) begin
            state <= RINGING;
            ring  <= 1'b1;
            cnt   <= RING_CNT;
          end
        end

        EDIT: begin
          if (!sel_mode) begin
            state      <= IDLE;
            alarm_mode <= FLD_NONE;
          end else if (p_mid) begin
            state      <= IDLE;
            alarm_mode <= FLD_NONE;
            armed      <= 1'b1;
          end else if (p_up || p_dn) begin
            case (alarm_mode)
              FLD_SEC:  al_sec  <= fld_step(al_sec,  SEC_MAX,  p_up);
              FLD_MIN:  al_min  <= fld_step(al_min,  MIN_MAX,  p_up);
              FLD_HOUR: al_hour <= fld_step(al_hour, HOUR_MAX, p_up);
              default:  ;
            endcase
          end else if (p_lf) begin
            alarm_mode <= (alarm_mode == FLD_HOUR) ? FLD_SEC : 3'(alarm_mode + 3'd1);
          end else if (p_rt) begin
            alarm_mode <= (alarm_mode == FLD_SEC) ? FLD_HOUR : 3'(alarm_mode - 3'd1);
          end
        end

        RINGING: begin
          if (p_mid) begin
            state <= IDLE;
            ring  <= 1'b0;
          end else if (any_press) begin
            state <= SNOOZE;
            ring  <= 1'b0;
            cnt   <= SNOOZE_CNT;
          end else if (tick_1hz) begin
            if (cnt == 9'd0) begin
              state <= IDLE;
              ring  <= 1'b0;
            end else begin
              cnt <= cnt - 9'd1;
            end
          end
        end

        SNOOZE: begin
          if (p_mid) begin
            state <= IDLE;
          end else if (!any_press && tick_1hz) begin
            if (cnt == 9'd0) begin
              state <= RINGING;
              ring  <= 1'b1;
              cnt   <= RING_CNT;
            end else begin
              cnt <= cnt - 9'd1;
            end
          end
        end

        default: begin
          state <= IDLE;
          ring  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// tb/tb_alarm_ring_ctrl.sv - scoreboard bench for alarm_ring_ctrl
module tb_alarm_ring_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, middle = 1'b0;
  logic [3:0] mode = 4'd0;
  logic [5:0] cur_hour = 6'd0, cur_min = 6'd0, cur_sec = 6'd0;
  logic [2:0] alarm_mode;
  logic [5:0] al_hour, al_min, al_sec;
  logic       armed, ring;

  alarm_ring_ctrl #(
    .ALARM_MODE  (4'd3),
    .RING_SECS   (60),
    .SNOOZE_SECS (300)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_1hz   (tick_1hz),
    .up         (up),
    .down       (down),
    .left       (left),
    .right      (right),
    .middle     (middle),
    .mode       (mode),
    .cur_hour   (cur_hour),
    .cur_min    (cur_min),
    .cur_sec    (cur_sec),
    .alarm_mode (alarm_mode),
    .al_hour    (al_hour),
    .al_min     (al_min),
    .al_sec     (al_sec),
    .armed      (armed),
    .ring       (ring)
  );

  always #5 clk = ~clk;

  localparam logic [4:0] B_NONE = 5'b00000;
  localparam logic [4:0] B_MID  = 5'b10000;
  localparam logic [4:0] B_UP   = 5'b01000;
  localparam logic [4:0] B_DN   = 5'b00100;
  localparam logic [4:0] B_LF   = 5'b00010;
  localparam logic [4:0] B_RT   = 5'b00001;

  typedef struct {
    string tag;
    int    am;
    int    hr;
    int    mn;
    int    sc;
    int    arm;
    int    rg;
  } exp_t;

  exp_t  q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  // Expected outputs after the cycle being driven
  int    e_am = 0, e_hr = 0, e_mn = 0, e_sc = 0, e_arm = 0, e_rg = 0;
  string tag = "init";

  // Inputs applied on the next driven cycle
  logic [3:0] mode_v = 4'd3;
  logic [5:0] ch = 6'd0, cm = 6'd0, cs = 6'd0;

  task automatic check(input string name, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", name, obs, exp);
    end
  endtask

  task automatic cyc(input logic [4:0] btn, input logic tk);
    exp_t e;
    @(negedge clk);
    {middle, up, down, left, right} = btn;
    tick_1hz = tk;
    mode     = mode_v;
    cur_hour = ch;
    cur_min  = cm;
    cur_sec  = cs;
    e.tag = tag;
    e.am  = e_am;
    e.hr  = e_hr;
    e.mn  = e_mn;
    e.sc  = e_sc;
    e.arm = e_arm;
    e.rg  = e_rg;
    q.push_back(e);
  endtask

  task automatic press(input logic [4:0] btn);
    cyc(btn, 1'b0);
    cyc(B_NONE, 1'b0);
  endtask

  // Compare DUT outputs one step after the edge that consumed each entry
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check({e.tag, ".alarm_mode"}, int'(alarm_mode), e.am);
        check({e.tag, ".al_hour"},    int'(al_hour),    e.hr);
        check({e.tag, ".al_min"},     int'(al_min),     e.mn);
        check({e.tag, ".al_sec"},     int'(al_sec),     e.sc);
        check({e.tag, ".armed"},      int'(armed),      e.arm);
        check({e.tag, ".ring"},       int'(ring),       e.rg);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    mode   = 4'd3;
    middle = 1'b1;
    #12;
    check("reset.alarm_mode", int'(alarm_mode), 0);
    check("reset.al_hour",    int'(al_hour),    0);
    check("reset.al_min",     int'(al_min),     0);
    check("reset.al_sec",     int'(al_sec),     0);
    check("reset.armed",      int'(armed),      0);
    check("reset.ring",       int'(ring),       0);
    @(negedge clk);
    rst_n = 1'b1;

    tag = "held_mid";
    repeat (3) cyc(B_MID, 1'b0);
    cyc(B_NONE, 1'b0);

    tag = "edit_enter"; e_am = 1; press(B_MID);
    tag = "left";
    e_am = 2; press(B_LF);
    e_am = 3; press(B_LF);
    e_am = 1; press(B_LF);
    e_am = 2; press(B_LF);
    e_am = 3; press(B_LF);

    tag = "hour_up";
    for (int i = 0; i < 25; i++) begin
      e_hr = (e_hr + 1) % 24;
      press(B_UP);
    end

    tag = "arm"; e_am = 0; e_arm = 1; press(B_MID);

    tag = "set_0630"; e_am = 1; press(B_MID);
    e_am = 2; press(B_LF);
    for (int i = 0; i < 30; i++) begin
      e_mn = e_mn + 1;
      press(B_UP);
    end
    e_am = 3; press(B_LF);
    for (int i = 0; i < 5; i++) begin
      e_hr = e_hr + 1;
      press(B_UP);
    end
    e_am = 0; press(B_MID);

    tag = "no_match"; ch = 6'd6; cm = 6'd29; cs = 6'd59;
    cyc(B_NONE, 1'b1); cyc(B_NONE, 1'b0);

    tag = "match"; cm = 6'd30; cs = 6'd0; e_rg = 1;
    cyc(B_NONE, 1'b1); cyc(B_NONE, 1'b0);

    tag = "ring_len";
    for (int i = 1; i <= 60; i++) begin
      if (i == 60) e_rg = 0;
      cyc(B_NONE, 1'b1);
      cyc(B_NONE, 1'b0);
    end

    tag = "ring2"; e_rg = 1;
    cyc(B_NONE, 1'b1); cyc(B_NONE, 1'b0);

    tag = "snooze"; e_rg = 0; press(B_DN);
    for (int i = 1; i <= 300; i++) begin
      if (i == 300) e_rg = 1;
      cyc(B_NONE, 1'b1);
      cyc(B_NONE, 1'b0);
    end

    tag = "stop"; e_rg = 0; press(B_MID);
    ch = 6'd0; cm = 6'd0; cs = 6'd0;

    tag = "edit_min"; e_am = 1; press(B_MID);
    e_am = 3; press(B_RT);
    e_am = 2; press(B_RT);
    for (int i = 0; i < 30; i++) begin
      e_mn = e_mn - 1;
      press(B_DN);
    end
    tag = "min_wrap"; e_mn = 59; press(B_DN);

    tag = "mode_exit"; mode_v = 4'd0; e_am = 0;
    cyc(B_NONE, 1'b0);

    tag = "edit_match"; mode_v = 4'd3; e_am = 1; press(B_MID);
    ch = 6'd6; cm = 6'd59; cs = 6'd0;
    cyc(B_NONE, 1'b1); cyc(B_NONE, 1'b0);
    mode_v = 4'd0; e_am = 0;
    cyc(B_NONE, 1'b0);

    tag = "up_vs_tick"; mode_v = 4'd3; e_arm = 0;
    cyc(B_UP, 1'b1); cyc(B_NONE, 1'b0);

    tag = "disarmed";
    cyc(B_NONE, 1'b1); cyc(B_NONE, 1'b0);

    tag = "rearm"; e_arm = 1; press(B_UP);

    tag = "ring3"; e_rg = 1;
    cyc(B_NONE, 1'b1); cyc(B_NONE, 1'b0);

    @(posedge clk);
    #2;
    check("drain", q.size(), 0);

    rst_n = 1'b0;
    #1;
    check("async_rst.ring",       int'(ring),       0);
    check("async_rst.armed",      int'(armed),      0);
    check("async_rst.alarm_mode", int'(alarm_mode), 0);
    check("async_rst.al_hour",    int'(al_hour),    0);
    check("async_rst.al_min",     int'(al_min),     0);
    check("async_rst.al_sec",     int'(al_sec),     0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
